// File: rtl/dice_lights_pkg.sv
// dice_lights_pkg: shared types and helpers for the dice / traffic-light block.
//   light_t      - traffic sequencer phase
//   LIGHT_*      - {red, amber, green} encodings driven onto the LED bank
//   light_enc    - phase -> LED encoding
//   max_cyc      - largest of the four dwell counts
//   cnt_width    - dwell counter width (clog2, never narrower than 1 bit)
package dice_lights_pkg;

   typedef enum logic [1:0] {
      RED       = 2'd0,
      RED_AMBER = 2'd1,
      GREEN     = 2'd2,
      AMBER     = 2'd3
   } light_t;

   localparam logic [2:0] LIGHT_RED   = 3'b100;
   localparam logic [2:0] LIGHT_RA    = 3'b110;
   localparam logic [2:0] LIGHT_GREEN = 3'b001;
   localparam logic [2:0] LIGHT_AMBER = 3'b010;

   function automatic logic [2:0] light_enc(input light_t st);
      logic [2:0] enc;
      case (st)
         RED:       enc = LIGHT_RED;
         RED_AMBER: enc = LIGHT_RA;
         GREEN:     enc = LIGHT_GREEN;
         default:   enc = LIGHT_AMBER;
      endcase
      return enc;
   endfunction

   function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dice_lights_sel_traffic_seq.sv
// traffic_seq: RED -> RED_AMBER -> GREEN -> AMBER -> RED sequencer.
//   clk    - system clock
//   rst    - synchronous active-high reset (phase RED, dwell count 0)
//   freeze - holds phase and dwell count while high
//   lights - registered {red, amber, green}
module traffic_seq
   import dice_lights_pkg::*;
#(
   parameter int unsigned RED_CYC   = 4,
   parameter int unsigned RA_CYC    = 1,
   parameter int unsigned GREEN_CYC = 4,
   parameter int unsigned AMBER_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       freeze,
   output logic [2:0] lights
);

   localparam int unsigned CW = cnt_width(max_cyc(RED_CYC, RA_CYC, GREEN_CYC, AMBER_CYC));

   localparam logic [CW-1:0] RED_LAST   = CW'(RED_CYC - 1);
   localparam logic [CW-1:0] RA_LAST    = CW'(RA_CYC - 1);
   localparam logic [CW-1:0] GREEN_LAST = CW'(GREEN_CYC - 1);
   localparam logic [CW-1:0] AMBER_LAST = CW'(AMBER_CYC - 1);

   light_t        state;
   light_t        state_nxt;
   logic [CW-1:0] count;
   logic          last;

   always_comb begin
      last      = 1'b0;
      state_nxt = state;
      case (state)
         RED: begin
            last      = (count == RED_LAST);
            state_nxt = RED_AMBER;
         end
         RED_AMBER: begin
            last      = (count == RA_LAST);
            state_nxt = GREEN;
         end
         GREEN: begin
            last      = (count == GREEN_LAST);
            state_nxt = AMBER;
         end
         default: begin
            last      = (count == AMBER_LAST);
            state_nxt = RED;
         end
      endcase
   end

   // lights is loaded from the next phase on the same edge the phase
   // changes, so it is a flop output and can never show a transient code.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RED;
         count  <= '0;
         lights <= LIGHT_RED;
      end else if (!freeze) begin
         if (last) begin
            state  <= state_nxt;
            count  <= '0;
            lights <= light_enc(state_nxt);
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dice_lights_sel.sv
// dice_lights_sel: electronic die, traffic-light sequencer and registered
// output selector driving the LED bank.
//   clk       - system clock
//   rst       - synchronous active-high reset
//   button    - die rolls while high
//   freeze    - holds traffic phase and dwell count
//   sel       - result source: 0 = throw, 1 = lights
//   throw     - die value, 1..FACES
//   lights    - {red, amber, green}
//   roll_done - one-cycle pulse after button falls
//   result    - registered selection of throw / lights
module dice_lights_sel
   import dice_lights_pkg::*;
#(
   parameter int unsigned W         = 3,
   parameter int unsigned FACES     = 6,
   parameter int unsigned RED_CYC   = 4,
   parameter int unsigned RA_CYC    = 1,
   parameter int unsigned GREEN_CYC = 4,
   parameter int unsigned AMBER_CYC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         button,
   input  logic         freeze,
   input  logic         sel,
   output logic [W-1:0] throw,
   output logic [2:0]   lights,
   output logic         roll_done,
   output logic [W-1:0] result
);

   localparam logic [W-1:0] FACE_MAX = W'(FACES);
   localparam logic [W-1:0] FACE_MIN = W'(1);

   logic button_q;

   traffic_seq #(
      .RED_CYC   (RED_CYC),
      .RA_CYC    (RA_CYC),
      .GREEN_CYC (GREEN_CYC),
      .AMBER_CYC (AMBER_CYC)
   ) u_traffic_seq (
      .clk    (clk),
      .rst    (rst),
      .freeze (freeze),
      .lights (lights)
   );

   // Wrap on >= rather than == so throw cannot escape 1..FACES when W is
   // wider than FACES needs.
   always_ff @(posedge clk) begin
      if (rst) begin
         throw <= FACE_MIN;
      end else if (button) begin
         throw <= (throw >= FACE_MAX) ? FACE_MIN : throw + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         button_q  <= 1'b0;
         roll_done <= 1'b0;
      end else begin
         button_q  <= button;
         roll_done <= button_q & ~button;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
      end else begin
         result <= sel ? W'(lights) : throw;
      end
   end

endmodule

// File: tb/tb_dice_lights_sel.sv
module tb_dice_lights_sel;

   logic clk = 1'b0;
   logic rst, button, freeze, sel;

   logic [2:0] throw3, lights3, result3;
   logic       rd3;
   logic [3:0] throw4, result4;
   logic [2:0] lights4;
   logic       rd4;

   always #5 clk = ~clk;

   dice_lights_sel u_dut3 (
      .clk(clk), .rst(rst), .button(button), .freeze(freeze), .sel(sel),
      .throw(throw3), .lights(lights3), .roll_done(rd3), .result(result3)
   );

   dice_lights_sel #(.W(4), .FACES(10)) u_dut4 (
      .clk(clk), .rst(rst), .button(button), .freeze(freeze), .sel(sel),
      .throw(throw4), .lights(lights4), .roll_done(rd4), .result(result4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0] throw3;
      logic [3:0] throw4;
      logic [2:0] lights;
      logic       rd;
      logic [2:0] res3;
      logic [3:0] res4;
   } exp_t;

   exp_t sb[$];

   // reference model state
   int unsigned m_pos;
   logic [2:0]  m_throw3;
   logic [3:0]  m_throw4;
   logic        m_bq, m_rd;
   logic [2:0]  m_res3;
   logic [3:0]  m_res4;

   function automatic logic [2:0] light_of(input int unsigned pos);
      if (pos < 4)       return 3'b100;
      else if (pos == 4) return 3'b110;
      else if (pos < 9)  return 3'b001;
      else               return 3'b010;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, push the model's post-edge expectation,
   // then pop it and compare once the DUT has clocked.
   task automatic step(input logic r, input logic b, input logic f, input logic s);
      exp_t e;
      rst = r; button = b; freeze = f; sel = s;
      if (r) begin
         m_pos = 0; m_throw3 = 3'd1; m_throw4 = 4'd1;
         m_bq = 1'b0; m_rd = 1'b0; m_res3 = 3'd0; m_res4 = 4'd0;
      end else begin
         m_res3 = s ? light_of(m_pos) : m_throw3;
         m_res4 = s ? {1'b0, light_of(m_pos)} : m_throw4;
         m_rd   = m_bq & ~b;
         m_bq   = b;
         if (b) begin
            m_throw3 = (m_throw3 == 3'd6)  ? 3'd1 : m_throw3 + 3'd1;
            m_throw4 = (m_throw4 == 4'd10) ? 4'd1 : m_throw4 + 4'd1;
         end
         if (!f) m_pos = (m_pos + 1) % 10;
      end
      e.throw3 = m_throw3; e.throw4 = m_throw4; e.lights = light_of(m_pos);
      e.rd = m_rd; e.res3 = m_res3; e.res4 = m_res4;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("throw3",    32'(throw3),  32'(e.throw3));
      chk("throw4",    32'(throw4),  32'(e.throw4));
      chk("lights3",   32'(lights3), 32'(e.lights));
      chk("lights4",   32'(lights4), 32'(e.lights));
      chk("roll_done3", 32'(rd3),    32'(e.rd));
      chk("roll_done4", 32'(rd4),    32'(e.rd));
      chk("result3",   32'(result3), 32'(e.res3));
      chk("result4",   32'(result4), 32'(e.res4));
      chk("lights_legal", 32'(lights3 != 3'b000 && lights3 != 3'b111), 32'd1);
      chk("throw4_range", 32'(throw4 >= 4'd1 && throw4 <= 4'd10), 32'd1);
   endtask

   typedef struct {
      logic       r, b, f, s;
      logic [2:0] exp_throw;
      logic       exp_rd;
   } vec_t;

   vec_t tbl[21];

   initial begin
      int green_after;
      int red_cnt;
      logic [3:0] prev4;
      logic saw_wrap;

      tbl = '{
         '{1'b1,1'b1,1'b0,1'b0,3'd1,1'b0}, '{1'b1,1'b1,1'b0,1'b0,3'd1,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd2,1'b0}, '{1'b0,1'b1,1'b0,1'b0,3'd3,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd4,1'b0}, '{1'b0,1'b1,1'b0,1'b0,3'd5,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd6,1'b0}, '{1'b0,1'b1,1'b0,1'b0,3'd1,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd2,1'b0},
         '{1'b1,1'b0,1'b0,1'b0,3'd1,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd2,1'b0}, '{1'b0,1'b1,1'b0,1'b0,3'd3,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd4,1'b0}, '{1'b0,1'b1,1'b0,1'b0,3'd5,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd6,1'b0}, '{1'b0,1'b1,1'b0,1'b0,3'd1,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,3'd2,1'b0}, '{1'b0,1'b1,1'b0,1'b0,3'd3,1'b0},
         '{1'b0,1'b0,1'b0,1'b0,3'd3,1'b1}, '{1'b0,1'b0,1'b0,1'b0,3'd3,1'b0},
         '{1'b0,1'b0,1'b0,1'b0,3'd3,1'b0}
      };

      rst = 1'b1; button = 1'b0; freeze = 1'b0; sel = 1'b0;
      m_pos = 0; m_throw3 = 3'd1; m_throw4 = 4'd1;
      m_bq = 1'b0; m_rd = 1'b0; m_res3 = '0; m_res4 = '0;
      #2;

      // Reset, release roll sequence, roll-and-stop with roll_done pulse
      for (int i = 0; i < 21; i++) begin
         step(tbl[i].r, tbl[i].b, tbl[i].f, tbl[i].s);
         chk($sformatf("tbl_throw[%0d]", i), 32'(throw3), 32'(tbl[i].exp_throw));
         chk($sformatf("tbl_rd[%0d]", i),    32'(rd3),    32'(tbl[i].exp_rd));
      end

      // Sequence timing over three periods
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset_lights", 32'(lights3), 32'h4);
      chk("reset_result", 32'(result3), 32'h0);
      red_cnt = 0;
      for (int i = 1; i <= 30; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (i <= 10 && lights3 == 3'b100) red_cnt++;
         if (i % 10 == 0) chk("period_red", 32'(lights3), 32'h4);
         if (i % 10 == 4) chk("period_ra",  32'(lights3), 32'h6);
         if (i % 10 == 9) chk("period_amber", 32'(lights3), 32'h2);
      end
      chk("red_dwell", 32'(red_cnt), 32'd4);

      // Freeze in the middle of GREEN
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("green_before_freeze", 32'(lights3), 32'h1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk("green_frozen", 32'(lights3), 32'h1);
      end
      green_after = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (lights3 == 3'b001 && green_after == i) green_after++;
      end
      chk("green_after_release", 32'(green_after), 32'd2);

      // Selector latency with sel toggling while rolling
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'(i % 2));

      // Reset mid-roll and mid-GREEN, then long roll on the 10-face build
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("mid_green", 32'(lights4), 32'h1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("midrst_throw4",  32'(throw4),  32'h1);
      chk("midrst_lights4", 32'(lights4), 32'h4);
      chk("midrst_result4", 32'(result4), 32'h0);
      saw_wrap = 1'b0;
      for (int i = 0; i < 25; i++) begin
         prev4 = throw4;
         step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
         if (prev4 == 4'd10 && throw4 == 4'd1) saw_wrap = 1'b1;
      end
      chk("wrap_10_to_1", 32'(saw_wrap), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
